param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the number of entries; it SHALL be a power of two of at least 2.
REQ-003 Parameter ADD_SIZE, default 3, SHALL equal log2(FIFO_DEPTH) and SHALL set the width of the read and write pointers.
REQ-004 Parameter AF_THRESH, default 6, SHALL set the almost-full level (1..FIFO_DEPTH).
REQ-005 Parameter AE_THRESH, default 2, SHALL set the almost-empty level (0..FIFO_DEPTH-1).
REQ-006 Parameter FWFT, default 0, SHALL select the read mode: 0 is standard, 1 is first-word-fall-through.
REQ-007 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-008 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-009 wr_en  input  1  SHALL be the write request.
REQ-010 write_data  input  DATA_WIDTH  SHALL be the write word, sampled when a write is accepted.
REQ-011 rd_en  input  1  SHALL be the read/pop request.
REQ-012 read_data  output  DATA_WIDTH  SHALL be the read word.
REQ-013 empty, full, almost_empty, almost_full  output  1 each  SHALL be the occupancy flags.
REQ-014 count  output  ADD_SIZE+1  SHALL be the current occupancy, 0..FIFO_DEPTH.
REQ-015 overflow, underflow  output  1 each  SHALL be single-cycle error pulses.

Function
REQ-016 A write SHALL be accepted iff wr_en=1 and full=0; the word is stored at wr_ptr and wr_ptr increments modulo FIFO_DEPTH.
REQ-017 A read SHALL be accepted iff rd_en=1 and empty=0; rd_ptr increments modulo FIFO_DEPTH.
REQ-018 count SHALL be a register: +1 on write-only, -1 on read-only, and unchanged when both or neither are accepted.
REQ-019 The flags SHALL be decoded from registered count: full=(count==FIFO_DEPTH), empty=(count==0), almost_full=(count>=AF_THRESH), almost_empty=(count<=AE_THRESH); they SHALL reflect an operation in the cycle after it is accepted.
REQ-020 Simultaneous wr_en and rd_en SHALL be evaluated independently per REQ-016/017: at full, the read is accepted and the write is rejected; at empty, the write is accepted and the read is rejected.
REQ-021 overflow SHALL pulse high for one cycle, in the cycle after wr_en=1 with full=1; underflow SHALL pulse likewise after rd_en=1 with empty=1; rejected operations SHALL change no pointer, count or memory.
REQ-022 With FWFT=0, read_data SHALL be registered, SHALL update one cycle after an accepted read with the word at the old rd_ptr, and SHALL hold otherwise, including on underflow.
REQ-023 With FWFT=1, read_data SHALL equal mem[rd_ptr] whenever empty=0, with no rd_en needed; an accepted read pops and exposes the next word the following cycle; read_data SHALL be 0 while empty=1.
REQ-024 Data SHALL be returned in strict write order across pointer wrap-around.
REQ-025 Storage SHALL be a register array of FIFO_DEPTH x DATA_WIDTH.

Reset
REQ-026 When rst=1 at a clock edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, read_data=0; memory contents are not reset.
REQ-027 rst SHALL take priority over wr_en and rd_en in the same cycle.
REQ-028 Reset asserted mid-operation SHALL discard all stored words.

Verification (DATA_WIDTH=8, FIFO_DEPTH=8, AF_THRESH=6, AE_THRESH=2)
REQ-029 Reset: rst=1 for 2 cycles -> count=0, empty=1, almost_empty=1, full=0, read_data=0x00, no error pulses.
REQ-030 Fill, FWFT=0: write 0x11..0x88 -> almost_empty drops when count=3, almost_full rises when count=6, full=1 at count=8; a 9th write of 0x99 -> one-cycle overflow, count stays 8.
REQ-031 Drain, FWFT=0: 8 reads -> read_data 0x11..0x88 each one cycle after rd_en, empty=1 after the last read; a 9th read -> one-cycle underflow, read_data holds 0x88.
REQ-032 Wrap and simultaneous: write 5, read 5, write 4, then wr_en=rd_en=1 for 10 cycles with an incrementing pattern -> count stays 4 and order is preserved; at full with both asserted -> read accepted, overflow pulse, count=7.
REQ-033 FWFT=1: write 0xA5 then 0x5A -> the cycle after the first write, empty=0 and read_data=0xA5 with rd_en=0; one rd_en -> read_data=0x5A the next cycle.
REQ-034 Mid-operation reset: count=5, assert rst for 1 cycle -> next cycle count=0, empty=1; a following rd_en -> underflow pulse.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with parameterised width/depth, occupancy flags and error pulses.
// Latency: standard mode returns read data one cycle after an accepted read; FWFT mode shows the head word combinationally.
// Backpressure: writes are dropped while full, reads are ignored while empty; each rejected request raises a one-cycle error pulse.
module param_sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int ADD_SIZE   = 3,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADD_SIZE:0]     count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADD_SIZE:0]   DEPTH_C = (ADD_SIZE+1)'(FIFO_DEPTH);
   localparam logic [ADD_SIZE:0]   AF_C    = (ADD_SIZE+1)'(AF_THRESH);
   localparam logic [ADD_SIZE:0]   AE_C    = (ADD_SIZE+1)'(AE_THRESH);
   localparam logic [ADD_SIZE-1:0] PTR_ONE = ADD_SIZE'(1);
   localparam logic [ADD_SIZE:0]   CNT_ONE = (ADD_SIZE+1)'(1);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [ADD_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADD_SIZE-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADD_SIZE:0]     count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;

   // Flags are pure decodes of the registered occupancy, so they lag an operation by one cycle.
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // Read and write acceptance are judged independently against the current flags.
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   // Next-state for pointers, occupancy and error pulses.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = wr_en && full;
      underflow_d = rd_en && empty;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Control state; reset wins over any request in the same cycle and discards stored words.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array; contents are deliberately left unreset, only the pointers are cleared.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) mem_q[wr_ptr_q] <= write_data;
   end

   if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;
      // Registered read port: loads the head word on an accepted read, holds otherwise.
      always_ff @(posedge clk) begin
         if (rst)         rdata_q <= '0;
         else if (rd_acc) rdata_q <= mem_q[rd_ptr_q];
      end
      assign read_data = rdata_q;
   end else begin : g_fwft
      // Head word is always visible; forced to zero while nothing is stored.
      assign read_data = empty ? '0 : mem_q[rd_ptr_q];
   end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: one standard-mode and one FWFT-mode instance.
// Stimulus pushes expected post-edge state into a queue; a negedge monitor pops and compares.
// Directed sequences cover reset, fill/overflow, drain/underflow, wrap, simultaneous ops and FWFT.
module tb_param_sync_fifo;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, wr0, rd0, rst1, wr1, rd1;
   logic [7:0] wd0, wd1;
   logic [7:0] rdat0, rdat1;
   logic       em0, fu0, ae0, af0, ov0, un0;
   logic       em1, fu1, ae1, af1, ov1, un1;
   logic [3:0] cnt0, cnt1;

   param_sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .ADD_SIZE(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_std (
      .clk(clk), .rst(rst0), .wr_en(wr0), .write_data(wd0), .rd_en(rd0), .read_data(rdat0),
      .empty(em0), .full(fu0), .almost_empty(ae0), .almost_full(af0), .count(cnt0),
      .overflow(ov0), .underflow(un0));

   param_sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .ADD_SIZE(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst1), .wr_en(wr1), .write_data(wd1), .rd_en(rd1), .read_data(rdat1),
      .empty(em1), .full(fu1), .almost_empty(ae1), .almost_full(af1), .count(cnt1),
      .overflow(ov1), .underflow(un1));

   typedef struct {
      int         due;
      int         d;
      logic [7:0] rdat;
      logic [3:0] cnt;
      logic [5:0] flg;     // {empty, almost_empty, full, almost_full, overflow, underflow}
      bit         all;     // compare flags too, or only data+count
      string      name;
   } exp_t;

   exp_t       sb[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   // Reference model state: plain queues, one per instance.
   logic [7:0] mq0[$];
   logic [7:0] mq1[$];
   logic [7:0] hold0 = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due in this cycle against the DUT outputs.
   always @(negedge clk) begin
      while (sb.size() != 0 && sb[0].due <= cyc) begin
         exp_t x;
         logic [7:0] ard;
         logic [3:0] acn;
         logic [5:0] afl;
         bit bad;
         x   = sb.pop_front();
         ard = (x.d == 0) ? rdat0 : rdat1;
         acn = (x.d == 0) ? cnt0 : cnt1;
         afl = (x.d == 0) ? {em0, ae0, fu0, af0, ov0, un0} : {em1, ae1, fu1, af1, ov1, un1};
         checks = checks + 1;
         bad = (x.due != cyc) || (ard !== x.rdat) || (acn !== x.cnt) || (x.all && (afl !== x.flg));
         if (bad) begin
            errors = errors + 1;
            $display("FAIL %s dut%0d cyc%0d: got data=%h count=%0d flags=%b, want data=%h count=%0d flags=%b%s",
                     x.name, x.d, cyc, ard, acn, afl, x.rdat, x.cnt, x.flg, x.all ? "" : " (flags not compared)");
         end
      end
   end

   // One clock of stimulus on instance d; the model predicts the state after the edge.
   task automatic op(input int d, input bit r, input bit w, input logic [7:0] wd, input bit rd, input string nm);
      logic [7:0] q[$];
      logic [7:0] h;
      bit f, e, ov, un;
      int sz;
      exp_t x;
      {rst0, wr0, wd0, rd0} = '0;
      {rst1, wr1, wd1, rd1} = '0;
      if (d == 0) begin
         {rst0, wr0, wd0, rd0} = {r, w, wd, rd};
         q = mq0;
      end else begin
         {rst1, wr1, wd1, rd1} = {r, w, wd, rd};
         q = mq1;
      end
      h  = hold0;
      ov = 1'b0;
      un = 1'b0;
      if (r) begin
         q.delete();
         h = 8'h00;
      end else begin
         f  = (q.size() == 8);
         e  = (q.size() == 0);
         ov = w && f;
         un = rd && e;
         if (rd && !e) h = q.pop_front();
         if (w && !f) q.push_back(wd);
      end
      sz = q.size();
      x.due  = cyc + 1;
      x.d    = d;
      x.cnt  = 4'(sz);
      x.flg  = {sz == 0, sz <= 2, sz == 8, sz >= 6, ov, un};
      x.all  = 1'b1;
      x.name = nm;
      if (d == 0) begin
         mq0    = q;
         hold0  = h;
         x.rdat = h;
      end else begin
         mq1    = q;
         x.rdat = (sz != 0) ? q[0] : 8'h00;
      end
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   // Hand-computed data/count expectation for the state produced by the preceding op.
   task automatic hand(input int d, input logic [7:0] rdat, input logic [3:0] cnt, input string nm);
      exp_t x;
      x.due  = cyc;
      x.d    = d;
      x.rdat = rdat;
      x.cnt  = cnt;
      x.flg  = '0;
      x.all  = 1'b0;
      x.name = nm;
      sb.push_back(x);
   endtask

   initial begin
      {rst0, wr0, wd0, rd0} = '0;
      {rst1, wr1, wd1, rd1} = '0;
      @(posedge clk);
      #1;

      // Reset both instances for two cycles.
      op(0, 1, 0, 8'h00, 0, "rst0_a");
      op(0, 1, 0, 8'h00, 0, "rst0_b");
      hand(0, 8'h00, 4'd0, "rst0_hand");
      op(1, 1, 0, 8'h00, 0, "rst1_a");
      op(1, 1, 0, 8'h00, 0, "rst1_b");
      hand(1, 8'h00, 4'd0, "rst1_hand");

      // Fill 0x11..0x88, then one write too many.
      for (int i = 1; i <= 8; i++) op(0, 0, 1, 8'(i * 17), 0, "fill");
      hand(0, 8'h00, 4'd8, "fill_full_cnt");
      op(0, 0, 1, 8'h99, 0, "overflow");
      hand(0, 8'h00, 4'd8, "overflow_cnt");
      op(0, 0, 0, 8'h00, 0, "overflow_clear");

      // Drain in order, then one read too many.
      for (int i = 1; i <= 8; i++) begin
         op(0, 0, 0, 8'h00, 1, "drain");
         hand(0, 8'(i * 17), 4'(8 - i), "drain_hand");
      end
      op(0, 0, 0, 8'h00, 1, "underflow");
      hand(0, 8'h88, 4'd0, "underflow_hold");
      op(0, 0, 0, 8'h00, 0, "underflow_clear");

      // Move the pointers, then stream with simultaneous read and write across the wrap.
      for (int i = 0; i < 5; i++) op(0, 0, 1, 8'(8'h01 + i), 0, "wrap_wr5");
      for (int i = 0; i < 5; i++) op(0, 0, 0, 8'h00, 1, "wrap_rd5");
      hand(0, 8'h05, 4'd0, "wrap_rd5_last");
      for (int i = 0; i < 4; i++) op(0, 0, 1, 8'(8'h10 + i), 0, "wrap_wr4");
      for (int i = 0; i < 10; i++) op(0, 0, 1, 8'(8'h20 + i), 1, "simul");
      hand(0, 8'h25, 4'd4, "simul_hand");
      for (int i = 0; i < 4; i++) op(0, 0, 1, 8'(8'h40 + i), 0, "refill");
      hand(0, 8'h25, 4'd8, "refill_full");
      op(0, 0, 1, 8'hEE, 1, "full_both");
      hand(0, 8'h26, 4'd7, "full_both_hand");
      op(0, 0, 0, 8'h00, 0, "full_both_idle");
      for (int i = 0; i < 7; i++) op(0, 0, 0, 8'h00, 1, "final_drain");
      hand(0, 8'h43, 4'd0, "final_drain_last");

      // Reset with data stored, then a read must underflow.
      for (int i = 0; i < 5; i++) op(0, 0, 1, 8'(8'hC0 + i), 0, "mid_wr");
      op(0, 1, 1, 8'hFF, 1, "mid_rst");
      hand(0, 8'h00, 4'd0, "mid_rst_hand");
      op(0, 0, 0, 8'h00, 1, "mid_underflow");
      op(0, 0, 0, 8'h00, 0, "mid_idle");

      // First-word-fall-through instance.
      op(1, 0, 1, 8'hA5, 0, "fwft_wr1");
      hand(1, 8'hA5, 4'd1, "fwft_fall");
      op(1, 0, 1, 8'h5A, 0, "fwft_wr2");
      hand(1, 8'hA5, 4'd2, "fwft_hold");
      op(1, 0, 0, 8'h00, 0, "fwft_idle");
      op(1, 0, 0, 8'h00, 1, "fwft_pop1");
      hand(1, 8'h5A, 4'd1, "fwft_next");
      op(1, 0, 0, 8'h00, 1, "fwft_pop2");
      hand(1, 8'h00, 4'd0, "fwft_empty_zero");
      op(1, 0, 0, 8'h00, 1, "fwft_underflow");
      op(1, 0, 0, 8'h00, 0, "fwft_end");

      repeat (3) @(posedge clk);
      #1;
      checks = checks + 1;
      if (sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
